// File: rtl/conv_accum.sv
// conv_accum: 25-product window accumulator with bias, rounding, rescale and 9-bit saturation; `CONV_RELU_EN clamps negative results to 0
module conv_accum #(
    parameter int BIAS_SHIFT = 7,
    parameter int OUT_SHIFT  = 7,
    parameter int ACC_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prod_valid,
    input  logic                prod_first,
    input  logic signed [17:0]  prod_1,
    input  logic signed [17:0]  prod_2,
    input  logic signed [17:0]  prod_3,
    input  logic signed [17:0]  prod_4,
    input  logic signed [17:0]  prod_5,
    input  logic signed [8:0]   bias,
    output logic                conv_valid,
    output logic signed [8:0]   conv_data,
    output logic                seq_err
);
    typedef logic signed [ACC_W-1:0] acc_t;
    localparam acc_t RND  = acc_t'(1) << (OUT_SHIFT - 1);
    localparam acc_t MAXV = acc_t'(255);
    localparam acc_t MINV = acc_t'(-256);
    logic [2:0] col;
    logic start, cont, err;
    logic s1_v, s1_first, s1_last, s2_v, s3_v;
    logic signed [8:0] bias1, bias2, sat;
    acc_t sum, sum5, acc, bias_al, t, sh, res, s3_sh;
    always_comb begin
        start   = prod_valid & prod_first;
        cont    = prod_valid & ~prod_first & (col != 3'd0);
        err     = prod_valid & (prod_first == (col != 3'd0));
        sum     = acc_t'(prod_1) + acc_t'(prod_2) + acc_t'(prod_3) + acc_t'(prod_4) + acc_t'(prod_5);
        bias_al = acc_t'(bias2) <<< BIAS_SHIFT;
        t       = acc + bias_al + RND;
        sh      = t >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
        res     = sh < acc_t'(0) ? acc_t'(0) : sh;
`else
        res     = sh;
`endif
        sat     = s3_sh > MAXV ? 9'h0ff : s3_sh < MINV ? 9'h100 : s3_sh[8:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= 3'd0;
            s1_v       <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            sum5       <= '0;
            acc        <= '0;
            s3_sh      <= '0;
            bias1      <= '0;
            bias2      <= '0;
            conv_valid <= 1'b0;
            conv_data  <= '0;
            seq_err    <= 1'b0;
        end else begin
            col      <= start ? 3'd1 : cont ? (col == 3'd4 ? 3'd0 : col + 3'd1) : col;
            s1_v     <= start | cont;
            s1_first <= start;
            s1_last  <= cont & (col == 3'd4);
            sum5     <= sum;
            if (start) bias1 <= bias;
            // a first beat reloads the accumulator, which also discards any aborted partial window
            if (s1_v) acc <= s1_first ? sum5 : acc + sum5;
            if (s1_v & s1_first) bias2 <= bias1;
            s2_v       <= s1_v & s1_last;
            s3_v       <= s2_v;
            s3_sh      <= res;
            conv_valid <= s3_v;
            if (s3_v) conv_data <= sat;
            seq_err    <= err;
        end
    end
endmodule

// File: tb/tb_conv_accum.sv
// tb_conv_accum: table vectors, framing/reset sequences and random beats checked against a window-level arithmetic model
module tb_conv_accum;
    localparam int BS = 7;
    localparam int OS = 7;
`ifdef CONV_RELU_EN
    localparam int NEG_EXP = 0;
`else
    localparam int NEG_EXP = -256;
`endif
    logic clk = 0, rst = 1, prod_valid = 0, prod_first = 0;
    logic signed [17:0] p1 = 0, p2 = 0, p3 = 0, p4 = 0, p5 = 0;
    logic signed [8:0] bias = 0;
    logic conv_valid, seq_err;
    logic signed [8:0] conv_data;
    int tests = 0, fails = 0, cyc = 0, pulses = 0, errs = 0, held = 0;
    int mcol = 0, mbias = 0;
    longint msum = 0;
    bit mon_on = 0;
    typedef struct { int due; int val; } exp_t;
    typedef struct { string name; int p; int b; int exp; } vec_t;
    exp_t q[$];
    bit err_at[int];
    int pc[$], pv[$];

    conv_accum #(.BIAS_SHIFT(BS), .OUT_SHIFT(OS), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_first(prod_first),
        .prod_1(p1), .prod_2(p2), .prod_3(p3), .prod_4(p4), .prod_5(p5),
        .bias(bias), .conv_valid(conv_valid), .conv_data(conv_data), .seq_err(seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic signed [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int model_out(input longint s, input int b);
        longint r;
        r = (s + longint'(b) * (longint'(1) <<< BS) + (longint'(1) <<< (OS - 1))) >>> OS;
`ifdef CONV_RELU_EN
        if (r < 0) r = 0;
`endif
        return r > 255 ? 255 : r < -256 ? -256 : int'(r);
    endfunction

    task automatic beat(input bit f, input int a0, input int a1, input int a2, input int a3, input int a4, input int b);
        longint s;
        prod_valid = 1; prod_first = f; bias = b[8:0];
        p1 = a0[17:0]; p2 = a1[17:0]; p3 = a2[17:0]; p4 = a3[17:0]; p5 = a4[17:0];
        @(posedge clk); #1;
        prod_valid = 0; prod_first = 0;
        s = longint'(a0) + longint'(a1) + longint'(a2) + longint'(a3) + longint'(a4);
        if (f) begin
            if (mcol != 0) err_at[cyc] = 1;
            mcol = 1; mbias = b; msum = s;
        end else if (mcol == 0) begin
            err_at[cyc] = 1;
        end else begin
            msum += s; mcol++;
            if (mcol == 5) begin
                q.push_back('{cyc + 3, model_out(msum, mbias)});
                mcol = 0;
            end
        end
    endtask

    task automatic ubeat(input bit f, input int p, input int b);
        beat(f, p, p, p, p, p, b);
    endtask

    task automatic window(input int p, input int b);
        ubeat(1, p, b);
        for (int i = 0; i < 4; i++) ubeat(0, p, b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete(); held = 0; mcol = 0;
    endtask

    always @(negedge clk) begin
        bit due, e;
        int ev;
        if (mon_on) begin
            due = q.size() > 0 && q[0].due == cyc;
            ev = due ? q[0].val : held;
            if (conv_valid || due) begin
                tests++;
                if (!(conv_valid === 1'b1 && due && conv_data === ev[8:0])) begin
                    fails++;
                    $display("FAIL pulse @%0d: valid=%b data=%0d expected valid=%b data=%0d", cyc, conv_valid, conv_data, due, ev);
                end
                if (due) begin held = ev; void'(q.pop_front()); end
                if (conv_valid) begin pulses++; pc.push_back(cyc); pv.push_back(int'(conv_data)); end
            end else begin
                tests++;
                if (conv_data !== ev[8:0]) begin
                    fails++;
                    $display("FAIL hold @%0d: data=%0d expected %0d", cyc, conv_data, ev);
                end
            end
            e = err_at.exists(cyc);
            tests++;
            if (seq_err !== e) begin
                fails++;
                $display("FAIL seq_err @%0d: got %b expected %b", cyc, seq_err, e);
            end
            if (seq_err === 1'b1) errs++;
        end
    end

    initial begin
        vec_t tbl[6];
        int b0, e0;
        tbl[0] = '{"nominal", 128, 1, 26};
        tbl[1] = '{"sat_pos", 4096, 0, 255};
        tbl[2] = '{"sat_neg", -4096, 0, NEG_EXP};
        tbl[3] = '{"bias0", 128, 0, 25};
        tbl[4] = '{"bias_neg", 128, -1, 24};
        tbl[5] = '{"bias_max", 0, 255, 255};
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset conv_valid", conv_valid, 0);
        chk("reset conv_data", conv_data, 0);
        chk("reset seq_err", seq_err, 0);
        rst = 0; mon_on = 1;

        foreach (tbl[i]) begin
            b0 = pulses;
            window(tbl[i].p, tbl[i].b);
            idle(6);
            chk({tbl[i].name, " pulses"}, pulses - b0, 1);
            chk(tbl[i].name, conv_data, tbl[i].exp);
        end

        b0 = pulses;
        beat(1, 64, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) begin ubeat(0, 0, 0); idle(2); end
        idle(4);
        chk("round pulses", pulses - b0, 1);
        chk("round", conv_data, 1);

        b0 = pulses; e0 = errs;
        ubeat(0, 128, 0);
        idle(6);
        chk("idle_beat pulses", pulses - b0, 0);
        chk("idle_beat seq_err", errs - e0, 1);

        b0 = pulses; e0 = errs;
        ubeat(1, 128, 1); ubeat(0, 128, 1);
        window(128, 1);
        idle(6);
        chk("restart seq_err", errs - e0, 1);
        chk("restart pulses", pulses - b0, 1);
        chk("restart", conv_data, 26);

        pc.delete(); pv.delete();
        window(128, 0); window(128, 1); window(128, -1);
        idle(6);
        chk("b2b pulses", pc.size(), 3);
        if (pc.size() == 3) begin
            chk("b2b gap1", pc[1] - pc[0], 5);
            chk("b2b gap2", pc[2] - pc[1], 5);
            chk("b2b v0", pv[0], 25);
            chk("b2b v1", pv[1], 26);
            chk("b2b v2", pv[2], 24);
        end

        b0 = pulses;
        ubeat(1, 128, 1); ubeat(0, 128, 1); ubeat(0, 128, 1);
        do_reset();
        chk("post_reset data", conv_data, 0);
        window(128, 1);
        idle(6);
        chk("reset_win pulses", pulses - b0, 1);
        chk("reset_win", conv_data, 26);

        for (int i = 0; i < 600; i++) begin
            bit f;
            int a[5];
            f = (mcol == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 11) == 0);
            foreach (a[k]) a[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 262143)) - 131072
                                                               : int'($urandom_range(0, 1200)) - 600;
            beat(f, a[0], a[1], a[2], a[3], a[4], int'($urandom_range(0, 511)) - 256);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 249) == 0) do_reset();
        end
        idle(8);
        chk("outstanding", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
